// File: rtl/jag_dram_pkg.sv
// Shared types and default geometry for the page-mode DRAM responder.
package jag_dram_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROW_OPEN = 2'd1,
        COL      = 2'd2,
        CBR      = 2'd3
    } bank_st_e;

    // Single-cycle events a bank reports to the shared datapath.
    typedef struct packed {
        logic access;
        logic cbr;
        logic cas_err;
        logic trcd_err;
    } bank_evt_t;

    localparam int DEF_BANKS   = 2;
    localparam int DEF_DW      = 64;
    localparam int DEF_MAW     = 11;
    localparam int DEF_ROWB    = 9;
    localparam int DEF_COLB    = 9;
    localparam int DEF_CAS_LAT = 2;
    localparam int DEF_TRCD    = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jag_dram_if.sv
// Memory-side strobe/data bundle between a memory controller and the DRAM model.
interface jag_dram_if #(
    parameter int BANKS = 2,
    parameter int DW    = 64,
    parameter int MAW   = 11
);
    logic [BANKS-1:0]  xrasl;
    logic [BANKS-1:0]  xcasl;
    logic [MAW-1:0]    xma;
    logic              xoel;
    logic [DW/8-1:0]   xwel;
    logic [DW-1:0]     xd_in;
    logic [DW-1:0]     xd_out;
    logic              xd_oe;
    logic [15:0]       refcnt;
    logic              err_trcd;
    logic              err_cas;

    modport master (
        output xrasl, xcasl, xma, xoel, xwel, xd_in,
        input  xd_out, xd_oe, refcnt, err_trcd, err_cas
    );

    modport slave (
        input  xrasl, xcasl, xma, xoel, xwel, xd_in,
        output xd_out, xd_oe, refcnt, err_trcd, err_cas
    );
endinterface

// File: rtl/jag_dram_bank.sv
// One RAS/CAS pair: state machine, row latch and RAS-to-CAS delay counter.
module jag_dram_bank
    import jag_dram_pkg::*;
#(
    parameter int ROWB = DEF_ROWB,
    parameter int TRCD = DEF_TRCD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rasl,
    input  logic            casl,
    input  logic            ras_fall,
    input  logic            ras_rise,
    input  logic            cas_fall,
    input  logic            cas_rise,
    input  logic [ROWB-1:0] ma_row,
    output logic [ROWB-1:0] row,
    output bank_evt_t       ev
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ROW  = ROW_OPEN;
    localparam logic [1:0] S_COL  = COL;
    localparam logic [1:0] S_CBR  = CBR;

    logic [1:0] st;
    logic [7:0] cnt;
    logic       pend;
    logic       access;

    // A lone CAS fall with RAS high may still be the first half of a CBR, so
    // it only becomes an error if CAS rises again without RAS having fallen.
    always_comb begin
        access      = (st == S_ROW) && cas_fall && !rasl;
        ev.access   = access;
        ev.trcd_err = access && (int'(cnt) < TRCD);
        ev.cbr      = (st == S_IDLE) && ras_fall && !casl;
        ev.cas_err  = pend && cas_rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= S_IDLE;
            row  <= '0;
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            if (cnt != 8'hFF) cnt <= cnt + 8'd1;
            case (st)
                S_IDLE: begin
                    if (ras_fall) begin
                        pend <= 1'b0;
                        if (!casl) st <= S_CBR;
                        else begin
                            st  <= S_ROW;
                            row <= ma_row;
                            cnt <= 8'd1;
                        end
                    end else if (cas_fall && rasl) pend <= 1'b1;
                    else if (cas_rise) pend <= 1'b0;
                end
                S_ROW:   if (ras_rise) st <= S_IDLE; else if (access) st <= S_COL;
                S_COL:   if (ras_rise) st <= S_IDLE; else if (cas_rise) st <= S_ROW;
                default: if (ras_rise) st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/jag_dram_model.sv
// Page-mode DRAM responder: shared storage, CAS-latency read pipeline,
// bank arbitration, CBR refresh counting and sticky timing-error flags.
module jag_dram_model
    import jag_dram_pkg::*;
#(
    parameter int BANKS   = DEF_BANKS,
    parameter int DW      = DEF_DW,
    parameter int MAW     = DEF_MAW,
    parameter int ROWB    = DEF_ROWB,
    parameter int COLB    = DEF_COLB,
    parameter int CAS_LAT = DEF_CAS_LAT,
    parameter int TRCD    = DEF_TRCD
) (
    input  logic       xpclk,
    input  logic       xreset,
    jag_dram_if.slave  bus
);
    localparam int PW  = ROWB + COLB;
    localparam int AW  = $clog2(BANKS) + PW;
    localparam int BIW = idx_w(BANKS);
    localparam int NB  = DW / 8;

    logic [BANKS-1:0] ras_q, cas_q, ras_fall, ras_rise, cas_fall, cas_rise;
    logic [BANKS-1:0][ROWB-1:0] rows;
    bank_evt_t [BANKS-1:0] ev;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    assign ras_fall = ras_q & ~bus.xrasl;
    assign ras_rise = ~ras_q & bus.xrasl;
    assign cas_fall = cas_q & ~bus.xcasl;
    assign cas_rise = ~cas_q & bus.xcasl;

    always_ff @(posedge xpclk or posedge xreset) begin
        if (xreset) begin
            ras_q <= '1;
            cas_q <= '1;
        end else begin
            ras_q <= bus.xrasl;
            cas_q <= bus.xcasl;
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        jag_dram_bank #(.ROWB(ROWB), .TRCD(TRCD)) u_bank (
            .clk      (xpclk),
            .rst      (xreset),
            .rasl     (bus.xrasl[g]),
            .casl     (bus.xcasl[g]),
            .ras_fall (ras_fall[g]),
            .ras_rise (ras_rise[g]),
            .cas_fall (cas_fall[g]),
            .cas_rise (cas_rise[g]),
            .ma_row   (bus.xma[ROWB-1:0]),
            .row      (rows[g]),
            .ev       (ev[g])
        );
    end

    logic           win_vld, multi, wr, rd_launch, any_trcd, any_cas;
    logic [BIW-1:0] win;
    logic [AW-1:0]  addr;
    logic [2:0]     ncbr;

    // Descending scan so the lowest-indexed accessing bank is the one kept.
    always_comb begin
        win_vld  = 1'b0;
        multi    = 1'b0;
        win      = '0;
        ncbr     = '0;
        any_trcd = 1'b0;
        any_cas  = 1'b0;
        for (int b = BANKS-1; b >= 0; b--) begin
            if (ev[b].access) begin
                multi   = multi | win_vld;
                win_vld = 1'b1;
                win     = BIW'(b);
            end
            ncbr     = ncbr + 3'(ev[b].cbr);
            any_trcd = any_trcd | ev[b].trcd_err;
            any_cas  = any_cas | ev[b].cas_err;
        end
        addr      = AW'({rows[win], bus.xma[COLB-1:0]}) | (AW'(win) << PW);
        wr        = win_vld && (bus.xwel != '1);
        rd_launch = win_vld && !wr;
    end

    always_ff @(posedge xpclk) begin
        if (!xreset && wr)
            for (int i = 0; i < NB; i++)
                if (!bus.xwel[i]) mem[addr][i*8 +: 8] <= bus.xd_in[i*8 +: 8];
    end

    // Stage 0 is the launch cycle itself; stage CAS_LAT feeds the output latch.
    logic [CAS_LAT:0]           vld_pipe;
    logic [CAS_LAT:1]           vld_q;
    logic [CAS_LAT:0][DW-1:0]   dat_pipe;
    logic [CAS_LAT:1][DW-1:0]   dat_q;
    logic [CAS_LAT:0][BIW-1:0]  bnk_pipe;
    logic [CAS_LAT:1][BIW-1:0]  bnk_q;

    assign vld_pipe = {vld_q, rd_launch};
    assign dat_pipe = {dat_q, mem[addr]};
    assign bnk_pipe = {bnk_q, win};

    always_ff @(posedge xpclk or posedge xreset) begin
        if (xreset) vld_q <= '0;
        else        vld_q <= vld_pipe[CAS_LAT-1:0];
    end

    always_ff @(posedge xpclk) begin
        dat_q <= dat_pipe[CAS_LAT-1:0];
        bnk_q <= bnk_pipe[CAS_LAT-1:0];
    end

    logic           hv, hv_nxt;
    logic [BIW-1:0] hb, hb_nxt;
    logic [DW-1:0]  d_out;
    logic           d_oe;
    logic [15:0]    rcnt;
    logic           e_trcd, e_cas;

    // Delivered data stays driven only while its bank keeps CAS low.
    always_comb begin
        hv_nxt = hv;
        hb_nxt = hb;
        if (vld_pipe[CAS_LAT]) begin
            hv_nxt = 1'b1;
            hb_nxt = bnk_pipe[CAS_LAT];
        end
        if (bus.xcasl[hb_nxt]) hv_nxt = 1'b0;
    end

    always_ff @(posedge xpclk or posedge xreset) begin
        if (xreset) begin
            hv     <= 1'b0;
            hb     <= '0;
            d_out  <= '0;
            d_oe   <= 1'b0;
            rcnt   <= '0;
            e_trcd <= 1'b0;
            e_cas  <= 1'b0;
        end else begin
            hv     <= hv_nxt;
            hb     <= hb_nxt;
            if (vld_pipe[CAS_LAT]) d_out <= dat_pipe[CAS_LAT];
            d_oe   <= hv_nxt && !bus.xoel;
            rcnt   <= rcnt + 16'(ncbr);
            e_trcd <= e_trcd | any_trcd;
            e_cas  <= e_cas | any_cas | multi;
        end
    end

    assign bus.xd_out   = d_out;
    assign bus.xd_oe    = d_oe;
    assign bus.refcnt   = rcnt;
    assign bus.err_trcd = e_trcd;
    assign bus.err_cas  = e_cas;
endmodule

// File: doc/jag_dram_model.md
# jag_dram_model

Parametrised, synthesisable page-mode DRAM responder for the TOM/Jaguar simulation bench. It samples the multiplexed memory-side strobes (RAS/CAS per bank, MA, OE, per-byte WE) on the bench clock and answers with read data after a programmable CAS latency. It also counts CAS-before-RAS refreshes and flags timing violations. It replaces ad-hoc fixed-width memory stubs so one bench can exercise 32/64-bit buses, one or two banks, and different page geometries.

## Interface
- BANKS, 2, number of RAS/CAS pairs (1..4)
- DW, 64, data width in bits (multiple of 8)
- MAW, 11, multiplexed address width
- ROWB, 9, row bits used per bank (≤ MAW)
- COLB, 9, column bits used per bank (≤ MAW)
- CAS_LAT, 2, cycles from CAS fall to valid read data (≥ 1)
- TRCD, 2, minimum cycles RAS-fall to CAS-fall
- xpclk  in  1  bench clock, all sampling on rising edge
- xreset  in  1  asynchronous, active-high reset
- xrasl  in  BANKS  row strobes, active low
- xcasl  in  BANKS  column strobes, active low
- xma  in  MAW  multiplexed row/column address
- xoel  in  1  output enable, active low
- xwel  in  DW/8  byte write enables, active low
- xd_in  in  DW  write data from DUT
- xd_out  out  DW  read data
- xd_oe  out  1  xd_out valid/drive enable
- refcnt  out  16  CBR refresh count, wraps
- err_trcd  out  1  sticky: CAS fell < TRCD cycles after RAS
- err_cas  out  1  sticky: CAS fell while RAS high and not a CBR

## Operation
- Edges detected against the previous-cycle registered copy of each strobe; fall = prev 1, now 0.
- Per-bank FSM: IDLE -> ROW_OPEN on RAS fall with CAS high (latch row = xma[ROWB-1:0], clear trcd counter); IDLE -> CBR on RAS fall with CAS already low (refcnt+1, no access); ROW_OPEN -> COL on CAS fall; COL -> ROW_OPEN on CAS rise (page mode); ROW_OPEN/COL/CBR -> IDLE on RAS rise.
- CAS fall in ROW_OPEN: latch col = xma[COLB-1:0]; address = {row,col}. If any xwel low that cycle: write each enabled byte from xd_in in the same cycle; no read launched. Otherwise launch read.
- Read: data word captured at CAS fall, delivered through CAS_LAT-stage pipeline; xd_oe = 1 from CAS_LAT cycles after CAS fall while xoel low and that bank's CAS still low; otherwise xd_oe = 0, xd_out holds last value.
- Two banks with simultaneous CAS fall: lowest bank index wins the output pipeline; err_cas set.
- err_trcd set if CAS fall occurs with trcd counter < TRCD; access still performed.
- CAS fall while RAS high: err_cas set, ignored (CBR requires CAS before RAS, detected at RAS fall).
- Memory contents uninitialised (X in sim); not cleared by reset.

## Timing
- Reset: FSMs IDLE, strobe history all 1s, xd_out 0, xd_oe 0, refcnt 0, errors 0, pipeline flushed.
- Reset mid-access: pending read discarded, no write issued that cycle.
- Read latency exactly CAS_LAT cycles from the sampled CAS-fall edge to xd_oe=1.
- Write lands on the CAS-fall cycle; a read of the same address launched ≥1 cycle later returns new data.
- refcnt 0xFFFF + 1 -> 0x0000.

## Structure
- Package jag_dram_pkg: bank state enum (IDLE, ROW_OPEN, COL, CBR), default parameter constants.
- One sub-module jag_dram_bank (FSM, row latch, trcd counter) instantiated BANKS times; top holds shared storage array, read pipeline, arbitration, error/refresh logic.

## Test plan
- Write 0x0123456789ABCDEF row 5 col 3 bank 0 all bytes, then read same -> xd_oe rises exactly CAS_LAT=2 cycles after CAS fall, xd_out = 0x0123456789ABCDEF.
- Write only byte lane 0 (xwel=0xFE) with 0xFF over previous word -> readback 0x0123456789ABCDFF (lane 0 = bits 7:0).
- Page mode: one RAS, four CAS pulses cols 0..3 pre-loaded 1,2,3,4 -> four reads return 1,2,3,4, no errors.
- CAS low then RAS fall, repeated 3 times -> refcnt = 3, no memory change, err_cas = 0.
- CAS falls 1 cycle after RAS with TRCD=2 -> err_trcd = 1, sticky until xreset.
- Assert xreset during read pipeline -> xd_oe 0 next evaluation, all outputs at reset values, no stale data after release.
